// File: rtl/pair_stats_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : pair_stats_engine_if
//  Description : Sample-in / result-out bundle for pair_stats_engine.
//                The master (pattern source) drives in_valid/in_1/in_2 and
//                observes out_valid/out_1/out_2; the slave is the engine.
//  Revision    : 1.0  initial release
// ============================================================================
interface pair_stats_engine_if #(
    parameter int W   = 8,
    parameter int LEN = 4,
    parameter int OW  = 2*W + $clog2(LEN)
);
    logic                 in_valid;
    logic signed [W-1:0]  in_1;
    logic signed [W-1:0]  in_2;
    logic                 out_valid;
    logic [OW-1:0]        out_1;
    logic [OW-1:0]        out_2;

    modport master (
        output in_valid, in_1, in_2,
        input  out_valid, out_1, out_2
    );

    modport slave (
        input  in_valid, in_1, in_2,
        output out_valid, out_1, out_2
    );
endinterface
`default_nettype wire

// File: rtl/pair_stats_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pair_stats_engine
//  Description : Collects one burst of LEN signed (in_1, in_2) pairs and
//                reports dot product, greater-than count and per-stream
//                max/min as a fixed-length burst of result beats.
//                Optional: define PAIR_STATS_ABS_DIFF_EN to add a fourth
//                beat carrying sum(|in_1 - in_2|).
//  Revision    : 1.0  initial release
// ============================================================================
module pair_stats_engine #(
    parameter int W   = 8,
    parameter int LEN = 4,
    parameter int OW  = 2*W + $clog2(LEN)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    pair_stats_engine_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_bw  = $clog2(LEN);        // beat index width
    localparam int c_cw  = $clog2(LEN) + 1;    // greater-than count width
`ifdef PAIR_STATS_ABS_DIFF_EN
    localparam int c_out_num = 4;
    localparam int c_adw     = W + 1 + $clog2(LEN);  // abs-diff sum width
`else
    localparam int c_out_num = 3;
`endif

    localparam logic [c_bw-1:0] c_beat_one   = c_bw'(1);
    localparam logic [c_bw-1:0] c_beat_last  = c_bw'(LEN - 1);
    localparam logic [1:0]      c_obeat_last = 2'(c_out_num - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_next;

    logic [c_bw-1:0]        r_beat;     // pairs captured so far (mod LEN)
    logic [1:0]             r_obeat;    // result beat index while in OUT
    logic signed [2*W-1:0]  r_prod;     // product pipeline stage
    logic signed [OW-1:0]   r_acc;      // dot-product accumulator
    logic [c_cw-1:0]        r_gt;       // count of in_1 > in_2
    logic signed [W-1:0]    r_max1;
    logic signed [W-1:0]    r_max2;
    logic signed [W-1:0]    r_min1;
    logic signed [W-1:0]    r_min2;

    logic                   r_out_valid;
    logic [OW-1:0]          r_out_1;
    logic [OW-1:0]          r_out_2;

    logic signed [W-1:0]    w_in1;
    logic signed [W-1:0]    w_in2;
    logic signed [2*W-1:0]  w_prod;
    logic signed [OW-1:0]   w_prod_ext;
    logic                   w_gt;
    logic [c_cw-1:0]        w_gt_ext;
    logic                   w_beat_last;
    logic                   w_out_last;

`ifdef PAIR_STATS_ABS_DIFF_EN
    logic [c_adw-1:0]       r_abs;
    logic signed [W:0]      w_diff;
    logic [W:0]             w_absd;
    logic [c_adw-1:0]       w_absd_ext;
`endif

    // ------------------------------------------------------------------------
    // Combinational datapath helpers
    // ------------------------------------------------------------------------
    assign w_in1 = bus.in_1;
    assign w_in2 = bus.in_2;

    // Operands are sign-extended first so the full 2W-bit product is formed.
    assign w_prod     = $signed({{W{w_in1[W-1]}}, w_in1}) *
                        $signed({{W{w_in2[W-1]}}, w_in2});
    assign w_prod_ext = {{(OW-2*W){r_prod[2*W-1]}}, r_prod};
    assign w_gt       = (w_in1 > w_in2);   // ties are not counted
    assign w_gt_ext   = {{(c_cw-1){1'b0}}, w_gt};

    assign w_beat_last = (r_beat == c_beat_last);
    assign w_out_last  = (r_obeat == c_obeat_last);

`ifdef PAIR_STATS_ABS_DIFF_EN
    // One extra bit keeps the difference of two W-bit signed values exact.
    assign w_diff     = $signed({w_in1[W-1], w_in1}) - $signed({w_in2[W-1], w_in2});
    assign w_absd     = w_diff[W] ? -w_diff : w_diff;
    assign w_absd_ext = {{(c_adw-(W+1)){1'b0}}, w_absd};
`endif

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!bus.in_valid) begin
                    w_next = ST_IDLE;          // short burst: abort
                end else if (w_beat_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = ST_OUT;
            end
            ST_OUT: begin
                if (w_out_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture and accumulation of the incoming burst
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_prod <= '0;
            r_acc  <= '0;
            r_gt   <= '0;
            r_max1 <= '0;
            r_max2 <= '0;
            r_min1 <= '0;
            r_min2 <= '0;
`ifdef PAIR_STATS_ABS_DIFF_EN
            r_abs  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Beat 0 seeds every statistic, so max/min need no sentinel.
                    if (bus.in_valid) begin
                        r_beat <= c_beat_one;
                        r_prod <= w_prod;
                        r_acc  <= '0;
                        r_gt   <= w_gt_ext;
                        r_max1 <= w_in1;
                        r_max2 <= w_in2;
                        r_min1 <= w_in1;
                        r_min2 <= w_in2;
`ifdef PAIR_STATS_ABS_DIFF_EN
                        r_abs  <= w_absd_ext;
`endif
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        r_beat <= r_beat + c_beat_one;
                        r_prod <= w_prod;
                        r_acc  <= r_acc + w_prod_ext;
                        r_gt   <= r_gt + w_gt_ext;
                        if (w_in1 > r_max1) r_max1 <= w_in1;
                        if (w_in2 > r_max2) r_max2 <= w_in2;
                        if (w_in1 < r_min1) r_min1 <= w_in1;
                        if (w_in2 < r_min2) r_min2 <= w_in2;
`ifdef PAIR_STATS_ABS_DIFF_EN
                        r_abs  <= r_abs + w_absd_ext;
`endif
                    end else begin
                        r_beat <= '0;
                        r_prod <= '0;
                        r_acc  <= '0;
                        r_gt   <= '0;
                        r_max1 <= '0;
                        r_max2 <= '0;
                        r_min1 <= '0;
                        r_min2 <= '0;
`ifdef PAIR_STATS_ABS_DIFF_EN
                        r_abs  <= '0;
`endif
                    end
                end
                ST_DRAIN: begin
                    // Last product leaves the multiply stage here.
                    r_acc  <= r_acc + w_prod_ext;
                    r_prod <= '0;
                end
                default: begin
                    // ST_OUT: statistics held stable while results stream out.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Result beat sequencer; outputs are forced to zero outside ST_OUT
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_OUT)) begin
            r_out_valid <= 1'b0;
            r_out_1     <= '0;
            r_out_2     <= '0;
            r_obeat     <= 2'd0;
        end else begin
            r_out_valid <= 1'b1;
            r_obeat     <= r_obeat + 2'd1;
            case (r_obeat)
                2'd0: begin
                    r_out_1 <= r_acc;
                    r_out_2 <= {{(OW-c_cw){1'b0}}, r_gt};
                end
                2'd1: begin
                    r_out_1 <= {{(OW-W){r_max1[W-1]}}, r_max1};
                    r_out_2 <= {{(OW-W){r_max2[W-1]}}, r_max2};
                end
                2'd2: begin
                    r_out_1 <= {{(OW-W){r_min1[W-1]}}, r_min1};
                    r_out_2 <= {{(OW-W){r_min2[W-1]}}, r_min2};
                end
`ifdef PAIR_STATS_ABS_DIFF_EN
                2'd3: begin
                    r_out_1 <= {{(OW-c_adw){1'b0}}, r_abs};
                    r_out_2 <= '0;
                end
`endif
                default: begin
                    r_out_1 <= '0;
                    r_out_2 <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_1     = r_out_1;
    assign bus.out_2     = r_out_2;

endmodule
`default_nettype wire
